// File: rtl/amba3_apb_mem_slave_pkg.sv
// -----------------------------------------------------------------------------
// pkg_amba3
// Shared types and constants for the AMBA 3 APB memory completer.
//   amba3_apb_slave_state_t : transfer FSM state (IDLE, WAIT, RESP)
//   WCNT_W                  : width of the wait-state down-counter (0..15)
// -----------------------------------------------------------------------------
package pkg_amba3;

  // Transfer FSM: IDLE waits for a setup phase, WAIT burns the configured
  // wait states, RESP is the single cycle in which pready is high.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } amba3_apb_slave_state_t;

  // Wait-state counter width; covers WAIT_STATES = 0..15.
  localparam int WCNT_W = 4;

endpackage : pkg_amba3

// File: rtl/amba3_apb_mem_slave_mem_array.sv
// -----------------------------------------------------------------------------
// amba3_apb_mem_array
// Single-port synchronous word memory. One index serves both the
// combinational read and the clocked write.
//   pclk   in   clock, write on rising edge
//   we     in   write enable
//   idx    in   word index
//   wdata  in   write data
//   rdata  out  mem[idx], combinational
// -----------------------------------------------------------------------------
module amba3_apb_mem_array #(
  parameter int DEPTH     = 256,
  parameter int DATA_SIZE = 32,
  parameter int IDX_W     = $clog2(DEPTH)
) (
  input  logic                 pclk,
  input  logic                 we,
  input  logic [IDX_W-1:0]     idx,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  // NOTE: storage arrays get no reset; a reset branch would force the tool to
  // build the memory from flops and contents must survive preset_n anyway.
  always_ff @(posedge pclk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule : amba3_apb_mem_array

// File: rtl/amba3_apb_mem_slave.sv
// -----------------------------------------------------------------------------
// amba3_apb_mem_slave
// AMBA 3 APB completer backed by a word-addressed on-chip memory, with a
// parameterised number of wait states per access phase.
//
// Optional feature (compile-time macro AMBA3_APB_MEM_SLAVE_PSLVERR_EN):
//   defined   : accesses with non-zero address bits above the index complete
//               with pslverr=1, no write, prdata=0.
//   undefined : pslverr is tied 0 and such accesses alias onto the index.
//
// Ports:
//   pclk      in   APB clock
//   preset_n  in   asynchronous active-low reset
//   psel      in   slave select
//   penable   in   access-phase indicator
//   pwrite    in   1 = write, 0 = read
//   paddr     in   byte address   [ADDR_SIZE]
//   pwdata    in   write data     [DATA_SIZE]
//   prdata    out  read data      [DATA_SIZE], valid while pready=1 on a read
//   pready    out  transfer completion, one-cycle pulse
//   pslverr   out  error response, valid while pready=1
// -----------------------------------------------------------------------------
module amba3_apb_mem_slave
  import pkg_amba3::*;
#(
  parameter int ADDR_SIZE   = 32,
  parameter int DATA_SIZE   = 32,
  parameter int DEPTH       = 256,
  parameter int ADDR_LSB    = 2,
  parameter int WAIT_STATES = 0
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADDR_SIZE-1:0] paddr,
  input  logic [DATA_SIZE-1:0] pwdata,
  output logic [DATA_SIZE-1:0] prdata,
  output logic                 pready,
  output logic                 pslverr
);

  localparam int                IDX_W     = $clog2(DEPTH);
  localparam int                HI_LSB    = ADDR_LSB + IDX_W;
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_STATES);

`ifdef AMBA3_APB_MEM_SLAVE_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  amba3_apb_slave_state_t state_q, state_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d;

  // Transfer attributes captured in the setup phase.
  logic [IDX_W-1:0]       idx_q;
  logic                   write_q;
  logic                   in_range_q;

  // Address decode of the live bus.
  logic                   setup;
  logic [IDX_W-1:0]       idx_in;
  logic                   in_range_in;

  // Attributes of the transfer being completed this cycle. In IDLE the only
  // way into RESP is a zero-wait setup, so the live bus is used there.
  logic                   acc_write;
  logic                   acc_ok;
  logic                   ok_q;

  logic                   enter_resp;
  logic [DATA_SIZE-1:0]   prdata_d;
  logic                   pready_d;
  logic                   pslverr_d;

  logic                   mem_we;
  logic [IDX_W-1:0]       mem_idx;
  logic [DATA_SIZE-1:0]   mem_rdata;

  // Low address bits below the word index are deliberately ignored.
  logic                   unused_paddr;
  assign unused_paddr = ^paddr;

  assign setup       = psel & ~penable;
  assign idx_in      = paddr[ADDR_LSB +: IDX_W];
  assign in_range_in = ((paddr >> HI_LSB) == '0);

  assign acc_write   = (state_q == IDLE) ? pwrite : write_q;
  assign acc_ok      = !ERR_EN || ((state_q == IDLE) ? in_range_in : in_range_q);
  assign ok_q        = !ERR_EN || in_range_q;
  assign mem_idx     = (state_q == IDLE) ? idx_in : idx_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: defaults at the top of every combinational block keep each output
  // assigned on all paths, so no latches are inferred.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        // penable=1 without a prior setup is ignored here.
        if (setup) begin
          wcnt_d  = WAIT_LOAD;
          state_d = (WAIT_LOAD == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else begin
          // Keeps counting even if penable drops; that violation is ignored.
          wcnt_d = wcnt_q - 1'b1;
          if (wcnt_q == WCNT_W'(1)) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs and the memory write
  // ---------------------------------------------------------------------------
  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  always_comb begin
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    mem_we    = 1'b0;
    if (enter_resp) begin
      pready_d  = 1'b1;
      pslverr_d = ~acc_ok;
      if (!acc_write && acc_ok) begin
        prdata_d = mem_rdata;
      end
    end
    // The write commits on the edge that completes the transfer; an abort or
    // reset before that edge leaves the memory untouched.
    if ((state_q == RESP) && psel && penable && pready && write_q && ok_q) begin
      mem_we = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Setup-phase capture and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      idx_q      <= '0;
      write_q    <= 1'b0;
      in_range_q <= 1'b0;
    end else if ((state_q == IDLE) && setup) begin
      idx_q      <= idx_in;
      write_q    <= pwrite;
      in_range_q <= in_range_in;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      prdata  <= prdata_d;
      pready  <= pready_d;
      pslverr <= pslverr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  amba3_apb_mem_array #(
    .DEPTH     (DEPTH),
    .DATA_SIZE (DATA_SIZE),
    .IDX_W     (IDX_W)
  ) u_mem (
    .pclk  (pclk),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (pwdata),
    .rdata (mem_rdata)
  );

endmodule : amba3_apb_mem_slave

// File: tb/tb_amba3_apb_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_amba3_apb_mem_slave
// Two instances of the APB memory completer: dut 0 with no wait states and
// dut 1 with three. Expected values come from a word-array model of each
// memory that follows the address/aliasing/error rules of the block.
// Build with +define+AMBA3_APB_MEM_SLAVE_PSLVERR_EN to check the error build.
// -----------------------------------------------------------------------------
module tb_amba3_apb_mem_slave;

`ifdef AMBA3_APB_MEM_SLAVE_PSLVERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  always #5 pclk = ~pclk;

  amba3_apb_mem_slave #(.WAIT_STATES(WS0)) u_dut0 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
  );

  amba3_apb_mem_slave #(.WAIT_STATES(WS1)) u_dut1 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference memories: one word array per instance.
  logic [31:0] mdl    [2][256];
  bit          mvalid [2][256];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_write(input int d, input logic [31:0] addr, input logic [31:0] data);
    if (!ERR || addr[31:10] == 22'd0) begin
      mdl[d][addr[9:2]]    = data;
      mvalid[d][addr[9:2]] = 1'b1;
    end
  endtask

  task automatic bus_clear(input int d);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    pwrite[d]  = 1'b0;
    paddr[d]   = '0;
    pwdata[d]  = '0;
  endtask

  task automatic idle(input int d);
    @(negedge pclk);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  // One full APB transfer. Leaves psel/penable high after the completing
  // cycle so a following call forms a back-to-back transfer.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int len);
    int n;
    @(negedge pclk);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = wr ? wdata : $urandom;
    @(negedge pclk);
    penable[d] = 1'b1;
    n = 1;
    while (pready[d] !== 1'b1 && n < 40) begin
      @(negedge pclk);
      n++;
    end
    if (pready[d] !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout dut%0d addr 0x%08h: no pready within %0d cycles", d, addr, n);
    end
    rdata = prdata[d];
    err   = pslverr[d];
    len   = n + 1;
  endtask

  // Transfer checked against the reference model.
  task automatic do_xfer(input int d, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag);
    logic [31:0] rd, exp_rd;
    logic        er;
    bit          exp_er;
    int          len;
    exp_er = ERR && (addr[31:10] != 22'd0);
    exp_rd = (wr || exp_er) ? 32'd0 : mdl[d][addr[9:2]];
    xfer(d, wr, addr, wdata, rd, er, len);
    check({tag, " rdata"}, rd, exp_rd);
    check({tag, " pslverr"}, {31'd0, er}, {31'd0, exp_er});
    check({tag, " length"}, len, 2 + ws_of(d));
    if (wr) model_write(d, addr, wdata);
  endtask

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd;
    logic        er;
    int          len;
    bit          seen;
    int          n;

    bus_clear(0);
    bus_clear(1);

    // ---------------- reset values ----------------
    repeat (3) @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset dut%0d pready", d),  {31'd0, pready[d]},  32'd0);
      check($sformatf("reset dut%0d pslverr", d), {31'd0, pslverr[d]}, 32'd0);
      check($sformatf("reset dut%0d prdata", d),  prdata[d],           32'd0);
    end
    preset_n = 1'b1;

    // ---------------- table: zero-wait, back-to-back ----------------
    tbl.push_back('{1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0,                           1'b0});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678,                   1'b0});
    tbl.push_back('{1'b1, 32'h0000_0018, 32'h2244_6688, 32'h0,                           1'b0});
    tbl.push_back('{1'b1, 32'h0000_001C, 32'h0000_001C, 32'h0,                           1'b0});
    tbl.push_back('{1'b0, 32'h0000_0018, 32'h0,         32'h2244_6688,                   1'b0});
    tbl.push_back('{1'b0, 32'h0000_0013, 32'h0,         32'h1234_5678,                   1'b0});
    tbl.push_back('{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,                           1'b0});
    tbl.push_back('{1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D,                   1'b0});
    tbl.push_back('{1'b1, 32'h0000_0000, 32'h1111_0000, 32'h0,                           1'b0});
    tbl.push_back('{1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0,                           ERR});
    tbl.push_back('{1'b0, 32'h0000_0000, 32'h0,         ERR ? 32'h1111_0000 : 32'hDEAD_BEEF, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0400, 32'h0,         ERR ? 32'h0 : 32'hDEAD_BEEF,     ERR});
    tbl.push_back('{1'b0, 32'h0000_001C, 32'h0,         32'h0000_001C,                   1'b0});
    tbl.push_back('{1'b0, 32'h8000_0010, 32'h0,         ERR ? 32'h0 : 32'h1234_5678,     ERR});

    foreach (tbl[i]) begin
      xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].data, rd, er, len);
      check($sformatf("tbl[%0d] rdata", i), rd, tbl[i].exp_rdata);
      check($sformatf("tbl[%0d] pslverr", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
      check($sformatf("tbl[%0d] length", i), len, 2);
      if (tbl[i].wr) model_write(0, tbl[i].addr, tbl[i].data);
    end
    idle(0);
    check("tbl idle pready", {31'd0, pready[0]}, 32'd0);
    check("tbl idle prdata", prdata[0], 32'd0);

    // ---------------- wait states: dut1 ----------------
    do_xfer(1, 1'b1, 32'h0000_0040, 32'h4050_6070, "ws write");
    idle(1);
    check("ws write pready pulse", {31'd0, pready[1]}, 32'd0);
    do_xfer(1, 1'b0, 32'h0000_0040, 32'h0, "ws read");
    idle(1);
    check("ws read pready pulse", {31'd0, pready[1]}, 32'd0);
    check("ws read prdata after", prdata[1], 32'd0);

    // ---------------- abort during WAIT ----------------
    do_xfer(1, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, "abort pre");
    idle(1);
    @(negedge pclk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h0000_0020; pwdata[1] = 32'hA5A5_A5A5;
    @(negedge pclk);
    penable[1] = 1'b1;
    @(negedge pclk);
    psel[1] = 1'b0; penable[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge pclk);
      seen |= pready[1];
    end
    check("abort no pready", {31'd0, seen}, 32'd0);
    do_xfer(1, 1'b0, 32'h0000_0020, 32'h0, "abort readback");
    idle(1);

    // ---------------- reset while read is in RESP ----------------
    @(negedge pclk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 32'h0000_0040;
    @(negedge pclk);
    penable[1] = 1'b1;
    n = 0;
    while (pready[1] !== 1'b1 && n < 20) begin
      @(negedge pclk);
      n++;
    end
    check("rst resp pready before", {31'd0, pready[1]}, 32'd1);
    check("rst resp prdata before", prdata[1], 32'h4050_6070);
    #2 preset_n = 1'b0;
    #1;
    check("rst resp pready async", {31'd0, pready[1]}, 32'd0);
    check("rst resp prdata async", prdata[1], 32'd0);
    bus_clear(1);
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;

    // ---------------- reset during WAIT of a write ----------------
    do_xfer(1, 1'b1, 32'h0000_0024, 32'h1357_2468, "rst wait pre");
    idle(1);
    @(negedge pclk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h0000_0024; pwdata[1] = 32'hFFFF_0000;
    @(negedge pclk);
    penable[1] = 1'b1;
    @(negedge pclk);
    #2 preset_n = 1'b0;
    #1;
    check("rst wait pready", {31'd0, pready[1]}, 32'd0);
    check("rst wait prdata", prdata[1], 32'd0);
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    // Bus stays mid-access after release: not a setup, must be ignored.
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge pclk);
      seen |= pready[1];
    end
    check("rst wait no stale pready", {31'd0, seen}, 32'd0);
    idle(1);
    do_xfer(1, 1'b0, 32'h0000_0024, 32'h0, "rst wait readback");
    do_xfer(1, 1'b0, 32'h0000_0040, 32'h0, "rst survive 0x40");
    idle(1);
    do_xfer(0, 1'b0, 32'h0000_0010, 32'h0, "rst survive dut0");
    idle(0);

    // ---------------- randomized traffic vs model ----------------
    for (int i = 0; i < 120; i++) begin
      int          d;
      bit          wr;
      logic [7:0]  idx;
      logic [21:0] hi;
      logic [31:0] addr;
      d   = $urandom_range(0, 1);
      wr  = $urandom_range(0, 1) == 1;
      idx = 8'($urandom_range(0, 15) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 7));
      hi  = ($urandom_range(0, 5) == 0) ? 22'($urandom_range(1, 32'h3F_FFFF)) : 22'd0;
      addr = {hi, idx, 2'($urandom_range(0, 3))};
      if (!wr && !mvalid[d][idx]) wr = 1'b1;
      do_xfer(d, wr, addr, $urandom, $sformatf("rnd[%0d] dut%0d", i, d));
      if ($urandom_range(0, 2) == 0) idle(d);
    end
    idle(0);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_amba3_apb_mem_slave
